// File: rtl/ctrl_mc_pkg.sv
// sisc_ctrl_pkg: shared FSM state, opcode and ALU operation encodings for the SISC multicycle controller.
// No ports; imported by ctrl_mc and its sub-modules.
package sisc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_WB2,
    S_HALT
  } state_e;
  typedef enum logic [1:0] {
    ALU_ARITH     = 2'b00,
    ALU_ARITH_IMM = 2'b01,
    ALU_PASS      = 2'b10
  } alu_op_e;
  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;
endpackage

// File: rtl/ctrl_mc_if.sv
// ctrl_mc_if: bundle between the controller and IR/status/memory/datapath.
// Inputs to the controller: opcode, mm, stat, mem_ready, resume.
// Outputs from the controller: datapath controls, alu_op, mem_req, swp_phase, halted, bus_err.
// master = controller side, slave = datapath/environment side.
interface ctrl_mc_if #(
  parameter int OP_W = 4,
  parameter int CC_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [CC_W-1:0] mm;
  logic [CC_W-1:0] stat;
  logic            mem_ready;
  logic            resume;
  logic            rf_we;
  logic            wb_sel;
  logic            br_sel;
  logic            rb_sel;
  logic            ir_load;
  logic            pc_sel;
  logic            pc_write;
  logic            pc_rst;
  logic            mm_sel;
  logic            dm_we;
  logic [1:0]      alu_op;
  logic            mem_req;
  logic            swp_phase;
  logic            halted;
  logic            bus_err;
  modport master (
    input  opcode, mm, stat, mem_ready, resume,
    output rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
           mm_sel, dm_we, alu_op, mem_req, swp_phase, halted, bus_err
  );
  modport slave (
    output opcode, mm, stat, mem_ready, resume,
    input  rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
           mm_sel, dm_we, alu_op, mem_req, swp_phase, halted, bus_err
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts memory wait cycles and flags the MAX_WAIT-th consecutive one.
// Ports: clk, rst_f (async active-low), clr_i (restart count), en_i (waiting without ready),
// timeout_o (this waiting cycle is the last one allowed).
module ctrl_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  // cnt_q holds waits already spent, so this cycle is wait number cnt_q+1
  assign timeout_o = en_i && (cnt_q == W'(MAX_WAIT - 1));
endmodule

// File: rtl/ctrl_mc.sv
// ctrl_mc: SISC multicycle control FSM sequencing fetch/decode/execute/mem/writeback per opcode,
// with a bounded memory-ready wait and a HALT state left by a resume pulse.
// Ports: clk, rst_f (async active-low), bus (ctrl_mc_if.master: IR/status/handshake in, datapath controls out).
// Macro CTRL_SWP_EN: enables the two-write SWP sequence; otherwise SWP decodes as NOOP.
module ctrl_mc
  import sisc_ctrl_pkg::*;
#(
  parameter int              OP_W     = 4,
  parameter int              CC_W     = 4,
  parameter logic [CC_W-1:0] IMM_MODE = 4'b1000,
  parameter int              MAX_WAIT = 15
) (
  input logic       clk,
  input logic       rst_f,
  ctrl_mc_if.master bus
);
  state_e state_q, state_d;
  logic bus_err_q, waiting, timeout, hit, taken, mm_zero, imm;
  logic is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt, is_ls, in_ls_path;
  assign is_lod  = bus.opcode == OP_W'(OP_LOD);
  assign is_str  = bus.opcode == OP_W'(OP_STR);
  assign is_bra  = bus.opcode == OP_W'(OP_BRA);
  assign is_brr  = bus.opcode == OP_W'(OP_BRR);
  assign is_bne  = bus.opcode == OP_W'(OP_BNE);
  assign is_bnr  = bus.opcode == OP_W'(OP_BNR);
  assign is_alu  = bus.opcode == OP_W'(OP_ALU);
  assign is_hlt  = bus.opcode == OP_W'(OP_HLT);
  assign is_ls   = is_lod || is_str;
`ifdef CTRL_SWP_EN
  assign is_swp        = bus.opcode == OP_W'(OP_SWP);
  assign bus.swp_phase = state_q == S_WB2;
`else
  assign is_swp        = 1'b0;
  assign bus.swp_phase = 1'b0;
`endif
  assign mm_zero = bus.mm == '0;
  assign imm     = bus.mm == IMM_MODE;
  // mm=0 never hits, so BNE/BNR with mm=0 are always taken
  assign hit     = |(bus.mm & bus.stat);
  assign taken   = ((is_bra || is_brr) && hit) || ((is_bne || is_bnr) && !hit);
  assign waiting = state_q == S_FETCH || state_q == S_MEM;
  assign in_ls_path = is_ls && (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB);
  ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk       (clk),
    .rst_f     (rst_f),
    .clr_i     (!waiting || bus.mem_ready),
    .en_i      (waiting && !bus.mem_ready),
    .timeout_o (timeout)
  );
  assign bus.pc_rst   = state_q == S_START;
  assign bus.mem_req  = waiting;
  assign bus.ir_load  = state_q == S_FETCH && bus.mem_ready;
  assign bus.pc_sel   = state_q == S_DECODE && taken;
  assign bus.pc_write = bus.ir_load || bus.pc_sel;
  assign bus.br_sel   = state_q == S_DECODE && (is_bra || is_bne);
  assign bus.rb_sel   = is_str && (state_q == S_DECODE || state_q == S_EXECUTE || state_q == S_MEM);
  assign bus.wb_sel   = is_lod && (state_q == S_MEM || state_q == S_WB);
  assign bus.mm_sel   = in_ls_path ? mm_zero : 1'b1;
  assign bus.dm_we    = state_q == S_MEM && is_str && bus.mem_ready;
  assign bus.rf_we    = state_q == S_WB2 || (state_q == S_WB && (is_alu || is_lod || is_swp));
  assign bus.alu_op   = (state_q == S_EXECUTE && (is_alu || is_ls)) ?
                        (imm ? ALU_ARITH_IMM : ALU_ARITH) : ALU_PASS;
  assign bus.halted   = state_q == S_HALT;
  assign bus.bus_err  = bus_err_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:   state_d = S_FETCH;
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : timeout ? S_HALT : S_FETCH;
      S_DECODE:  state_d = is_hlt ? S_HALT : (is_alu || is_ls || is_swp) ? S_EXECUTE : S_FETCH;
      S_EXECUTE: state_d = is_ls ? S_MEM : S_WB;
      S_MEM:     state_d = bus.mem_ready ? (is_lod ? S_WB : S_FETCH) : timeout ? S_HALT : S_MEM;
      S_WB:      state_d = is_swp ? S_WB2 : S_FETCH;
      S_WB2:     state_d = S_FETCH;
      S_HALT:    state_d = (bus.resume && !bus_err_q) ? S_FETCH : S_HALT;
      default:   state_d = S_START;
    endcase
  end
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      state_q   <= S_START;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout) bus_err_q <= 1'b1;
    end
endmodule
